imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 160, byte capacity of the target instruction memory.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  begin a load session, sampled in IDLE or ERROR only.
REQ-005 base_addr  input  64  first byte address of the session, sampled with start.
REQ-006 word_in  input  32  instruction word to store, little-endian.
REQ-007 word_valid  input  1  word_in/word_last valid.
REQ-008 word_last  input  1  marks final word of the session.
REQ-009 word_ready  output  1  loader can accept a word this cycle.
REQ-010 mem_we  output  1  byte write strobe to instruction memory.
REQ-011 mem_addr  output  64  byte address of the current write.
REQ-012 mem_wdata  output  8  byte data of the current write.
REQ-013 cpu_hold  output  1  processor must not fetch while high.
REQ-014 done  output  1  one-cycle pulse at session completion.
REQ-015 error  output  1  sticky fault flag.
REQ-016 word_count  output  16  words written in the current or last session.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_WORD, WRITE, DONE and ERROR.
REQ-018 IDLE: word_ready=0, mem_we=0; start=1 with base_addr[1:0]==0 -> latch pointer=base_addr, word_count=0, go WAIT_WORD.
REQ-019 IDLE or ERROR: start=1 with base_addr[1:0]!=0 -> go ERROR, error=1, no write.
REQ-020 WAIT_WORD: word_ready=1; a handshake is word_valid&word_ready in the same cycle; on handshake, capture word_in and word_last.
REQ-021 Handshake with pointer+4 > MEM_BYTES -> go ERROR, error=1, no byte written, word_count unchanged.
REQ-022 Otherwise handshake -> go WRITE with byte index 0.
REQ-023 WRITE: mem_we=1, mem_addr=pointer+index, mem_wdata=captured word bits [8*index+7:8*index]; index advances 0->1->2->3, one byte per cycle.
REQ-024 WRITE with index 3: pointer+=4, word_count+=1; captured last -> DONE, else -> WAIT_WORD.
REQ-025 Latency: word accepted in cycle N -> bytes written in N+1..N+4 -> word_ready high again in N+5; throughput is 1 word per 5 cycles.
REQ-026 word_ready SHALL be 0 in every state except WAIT_WORD; word_valid outside WAIT_WORD is ignored and the word is not consumed.
REQ-027 DONE: done=1 for exactly one cycle -> IDLE.
REQ-028 cpu_hold=1 in WAIT_WORD, WRITE and DONE; 0 in IDLE and ERROR.
REQ-029 start asserted in WAIT_WORD, WRITE or DONE is ignored.
REQ-030 ERROR: error stays 1; start with an aligned base_addr clears error, resets word_count to 0 and goes WAIT_WORD.
REQ-031 When mem_we=0, mem_addr and mem_wdata hold their last values.
REQ-032 word_count holds its value in IDLE after DONE until the next accepted start.

Reset
REQ-033 reset=0 at a rising clk edge SHALL force IDLE with word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, word_count=0, byte index=0, pointer=0.
REQ-034 Reset during WRITE SHALL abort immediately; no further mem_we pulses; bytes already written are not undone.

Verification
REQ-035 base 0, start; one word 0x00000513 with last=1 -> mem_we on 4 consecutive cycles, addr/data 0:0x13, 1:0x05, 2:0x00, 3:0x00; done pulse; word_count=1.
REQ-036 base 4; words 0x02800593, 0x01200493 (last on second), word_valid held high -> addresses 4..11 written; word_ready low for 4 cycles between accepts; word_count=2.
REQ-037 MEM_BYTES=160, base 156; two words -> first written to 156..159; second handshake -> error=1, no write, word_count=1, cpu_hold=0.
REQ-038 start with base_addr=2 -> ERROR, error=1, no mem_we; then start with base 0 -> error=0, WAIT_WORD.
REQ-039 reset=0 asserted on the second WRITE cycle -> next cycle IDLE, all outputs at reset values; only bytes at addresses 0 and 1 were written.
REQ-040 start pulsed during WRITE, and word_valid held high during WRITE -> no restart; the held word is accepted only in the first WAIT_WORD cycle.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit instruction words into a byte-wide instruction memory
// Holds the CPU off the fetch path while a session is loading.
module imem_loader #(
  parameter int MEM_BYTES = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    WRITE     = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pointer;
  logic [1:0]  byte_idx;
  logic [31:0] word_q;
  logic        last_q;
  logic [63:0] addr_q;
  logic [7:0]  data_q;
  logic [15:0] count_q;

  logic        start_ok;
  logic        overflow;
  logic [63:0] cur_addr;
  logic [7:0]  cur_byte;

  assign start_ok = start && (base_addr[1:0] == 2'b00);
  // 65-bit sum so a pointer near the top of the address space cannot wrap past the check
  assign overflow = ({1'b0, pointer} + 65'd4) > 65'(MEM_BYTES);
  assign cur_addr = pointer + {62'd0, byte_idx};
  assign cur_byte = word_q[{byte_idx, 3'b000} +: 8];

  assign mem_addr   = mem_we ? cur_addr : addr_q;
  assign mem_wdata  = mem_we ? cur_byte : data_q;
  assign word_count = count_q;

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = start_ok ? WAIT_WORD : ERROR;
      end
      WAIT_WORD: begin
        word_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (word_valid) state_nxt = overflow ? ERROR : WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        if (byte_idx == 2'd3) state_nxt = last_q ? DONE : WAIT_WORD;
      end
      DONE: begin
        done      = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        error = 1'b1;
        if (start_ok) state_nxt = WAIT_WORD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pointer  <= 64'd0;
      byte_idx <= 2'd0;
      word_q   <= 32'd0;
      last_q   <= 1'b0;
      addr_q   <= 64'd0;
      data_q   <= 8'd0;
      count_q  <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == ERROR) && start_ok) begin
        pointer <= base_addr;
        count_q <= 16'd0;
      end
      if (state == WAIT_WORD && word_valid && !overflow) begin
        word_q   <= word_in;
        last_q   <= word_last;
        byte_idx <= 2'd0;
      end
      if (state == WRITE) begin
        addr_q   <= cur_addr;
        data_q   <= cur_byte;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          pointer <= pointer + 64'd4;
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
// A queue of pending byte writes stands in for the loader; every output is compared each cycle.
module tb_imem_loader;
  localparam int MEM_BYTES = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] base_addr = 64'd0;
  logic [31:0] word_in = 32'd0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        word_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
    .error(error), .word_count(word_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         q[$];
  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic        m_last = 1'b0;
  logic [63:0] m_ptr = 64'd0;
  logic [63:0] m_laddr = 64'd0;
  logic [7:0]  m_ldata = 8'd0;
  logic [15:0] m_count = 16'd0;
  logic [7:0]  img [0:255];
  int          wr_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin : model
    logic        ew;
    logic [63:0] ea;
    logic [7:0]  ed;
    wr_t         w;
    ew = (q.size() != 0);
    ea = ew ? q[0].a : m_laddr;
    ed = ew ? q[0].d : m_ldata;
    chk("mem_we", mem_we, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("word_ready", word_ready, m_active && !ew);
    chk("cpu_hold", cpu_hold, m_active || m_done);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("word_count", word_count, m_count);
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (mem_addr < 64'd256) img[mem_addr[7:0]] = mem_wdata;
    end
    if (done === 1'b1) done_cnt++;
    // advance the model by one clock using the inputs that the next edge will sample
    if (!reset) begin
      q.delete();
      m_active = 0; m_done = 0; m_err = 0; m_last = 0;
      m_ptr = 0; m_laddr = 0; m_ldata = 0; m_count = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (ew) begin
      m_laddr = q[0].a;
      m_ldata = q[0].d;
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_ptr   = m_ptr + 64'd4;
        m_count = m_count + 16'd1;
        if (m_last) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (m_active) begin
      if (word_valid) begin
        if (({1'b0, m_ptr} + 65'd4) > 65'(MEM_BYTES)) begin
          m_active = 0;
          m_err    = 1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            w.a = m_ptr + 64'(i);
            w.d = word_in[8*i +: 8];
            q.push_back(w);
          end
          m_last = word_last;
        end
      end
    end else if (start) begin
      if (base_addr[1:0] != 2'b00) m_err = 1;
      else begin
        m_err = 0; m_active = 1; m_ptr = base_addr; m_count = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [63:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input bit drop, output int n);
    logic hs;
    hs = 1'b0;
    n = 0;
    word_in = w;
    word_last = l;
    word_valid = 1'b1;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      hs = word_ready;
      n++;
      tick();
    end
    chk("handshake", hs, 1'b1);
    if (drop) word_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int w0;
    int d0;
    ticks(2);
    reset = 1'b1;
    tick();

    // single word at base 0
    d0 = done_cnt;
    do_start(64'd0);
    send_word(32'h0000_0513, 1'b1, 1'b1, n);
    ticks(6);
    chk("b0", img[0], 8'h13);
    chk("b1", img[1], 8'h05);
    chk("b2", img[2], 8'h00);
    chk("b3", img[3], 8'h00);
    chk("count_1", word_count, 16'd1);
    chk("model_count_1", m_count, 16'd1);
    chk("done_pulses", done_cnt - d0, 1);

    // two words with valid held high
    do_start(64'd4);
    send_word(32'h0280_0593, 1'b0, 1'b0, n);
    send_word(32'h0120_0493, 1'b1, 1'b1, n);
    chk("second_accept_wait", n, 5);
    ticks(6);
    chk("b4", img[4], 8'h93);
    chk("b7", img[7], 8'h02);
    chk("b8", img[8], 8'h93);
    chk("b11", img[11], 8'h01);
    chk("count_2", word_count, 16'd2);
    chk("model_count_2", m_count, 16'd2);

    // running off the end of memory
    w0 = wr_cnt;
    do_start(64'd156);
    send_word(32'h1122_3344, 1'b0, 1'b1, n);
    send_word(32'h5566_7788, 1'b1, 1'b1, n);
    ticks(2);
    chk("ovf_error", error, 1'b1);
    chk("ovf_count", word_count, 16'd1);
    chk("ovf_hold", cpu_hold, 1'b0);
    chk("ovf_writes", wr_cnt - w0, 4);
    chk("b156", img[156], 8'h44);
    chk("b159", img[159], 8'h11);

    // misaligned start, then recovery
    w0 = wr_cnt;
    do_start(64'd2);
    tick();
    chk("mis_error", error, 1'b1);
    chk("mis_writes", wr_cnt - w0, 0);
    do_start(64'd0);
    chk("recover_error", error, 1'b0);
    chk("recover_ready", word_ready, 1'b1);

    // reset on the second byte of a word
    w0 = wr_cnt;
    send_word(32'hAABB_CCDD, 1'b1, 1'b1, n);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_writes", wr_cnt - w0, 2);
    chk("rst_b0", img[0], 8'hDD);
    chk("rst_b1", img[1], 8'hCC);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_hold", cpu_hold, 1'b0);
    ticks(3);

    // start pulse and held valid during WRITE
    do_start(64'd8);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0, n);
    start = 1'b1;
    base_addr = 64'd40;
    tick();
    start = 1'b0;
    send_word(32'hCAFE_F00D, 1'b1, 1'b1, n);
    chk("held_accept_wait", n, 4);
    ticks(6);
    chk("held_count", word_count, 16'd2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 15) == 0);
      base_addr = 64'($urandom_range(0, 42)) * 64'd4;
      if ($urandom_range(0, 7) == 0) base_addr = base_addr + 64'($urandom_range(1, 3));
      word_valid = $urandom_range(0, 1) == 1;
      word_in = $urandom;
      word_last = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b1;
    start = 1'b0;
    word_valid = 1'b0;
    ticks(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
